// File: rtl/mask_bbox.sv
// rtl/mask_bbox.sv - per-frame bounding box and pixel count of mask==0 object pixels
module mask_bbox #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk_25,
  input  logic        rst_n,
  input  logic        valid,
  input  logic        mask,
  input  logic [9:0]  mask_x,
  input  logic [9:0]  mask_y,
  input  logic [19:0] min_count,
  output logic        box_valid,
  output logic        box_found,
  output logic [9:0]  box_x0,
  output logic [9:0]  box_x1,
  output logic [9:0]  box_y0,
  output logic [9:0]  box_y1,
  output logic [19:0] obj_count,
  output logic        frame_err
);

  localparam logic [9:0]  X_LAST    = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_LAST    = 10'(V_ACTIVE - 1);
  localparam logic [19:0] COUNT_MAX = 20'hFFFFF;

  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

  state_t      state, state_nx;
  logic [9:0]  min_x, max_x, min_y, max_y;
  logic [19:0] count;

  logic        in_range, is_origin, is_last, abort, finish, hit;
  logic [9:0]  base_min_x, base_max_x, base_min_y, base_max_y;
  logic [19:0] base_count;
  logic [9:0]  nx_min_x, nx_max_x, nx_min_y, nx_max_y;
  logic [19:0] nx_count;
  logic        nx_found;

  // Strobe classification: only in-range strobes are ever considered.
  always_comb begin
    in_range  = valid && (mask_x <= X_LAST) && (mask_y <= Y_LAST);
    is_origin = in_range && (mask_x == 10'd0) && (mask_y == 10'd0);
    is_last   = in_range && (mask_x == X_LAST) && (mask_y == Y_LAST);
    abort     = is_origin && (state == ACCUM);
    // An origin strobe always restarts, so it can never also close the frame.
    finish    = is_last && !is_origin && (state == ACCUM);
    // Origin strobes start a frame from any state and are themselves accumulated.
    hit       = in_range && !mask && ((state == ACCUM) || is_origin);
  end

  // Accumulator next values: reload at frame start, then apply the current pixel.
  always_comb begin
    base_min_x = is_origin ? 10'd1023 : min_x;
    base_max_x = is_origin ? 10'd0    : max_x;
    base_min_y = is_origin ? 10'd1023 : min_y;
    base_max_y = is_origin ? 10'd0    : max_y;
    base_count = is_origin ? 20'd0    : count;
    nx_min_x   = base_min_x;
    nx_max_x   = base_max_x;
    nx_min_y   = base_min_y;
    nx_max_y   = base_max_y;
    nx_count   = base_count;
    if (hit) begin
      if (mask_x < base_min_x) nx_min_x = mask_x;
      if (mask_x > base_max_x) nx_max_x = mask_x;
      if (mask_y < base_min_y) nx_min_y = mask_y;
      if (mask_y > base_max_y) nx_max_y = mask_y;
      if (base_count != COUNT_MAX) nx_count = base_count + 20'd1;
    end
    nx_found = (nx_count >= min_count) && (nx_count != 20'd0);
  end

  // FSM state register.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next-state: REPORT is a single cycle unless a new frame starts in it.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (is_origin) state_nx = ACCUM;
      ACCUM:   if (finish)    state_nx = REPORT;
      REPORT:  state_nx = is_origin ? ACCUM : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Working accumulators and registered frame results.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      min_x     <= '0;
      max_x     <= '0;
      min_y     <= '0;
      max_y     <= '0;
      count     <= '0;
      box_valid <= 1'b0;
      box_found <= 1'b0;
      box_x0    <= '0;
      box_x1    <= '0;
      box_y0    <= '0;
      box_y1    <= '0;
      obj_count <= '0;
      frame_err <= 1'b0;
    end else begin
      min_x     <= nx_min_x;
      max_x     <= nx_max_x;
      min_y     <= nx_min_y;
      max_y     <= nx_max_y;
      count     <= nx_count;
      box_valid <= finish;
      frame_err <= abort;
      if (finish) begin
        box_found <= nx_found;
        box_x0    <= nx_found ? nx_min_x : 10'd0;
        box_x1    <= nx_found ? nx_max_x : 10'd0;
        box_y0    <= nx_found ? nx_min_y : 10'd0;
        box_y1    <= nx_found ? nx_max_y : 10'd0;
        obj_count <= nx_count;
      end
    end
  end

endmodule

// File: tb/tb_mask_bbox.sv
// tb/tb_mask_bbox.sv - directed self-checking bench for mask_bbox
module tb_mask_bbox;

  logic        clk_25 = 1'b0;
  logic        rst_n;
  logic        valid;
  logic        mask;
  logic [9:0]  mask_x;
  logic [9:0]  mask_y;
  logic [19:0] min_count;
  logic        box_valid;
  logic        box_found;
  logic [9:0]  box_x0, box_x1, box_y0, box_y1;
  logic [19:0] obj_count;
  logic        frame_err;

  int tests_run = 0;
  int tests_failed = 0;
  int bv_cnt = 0;
  int fe_cnt = 0;

  mask_bbox #(.H_ACTIVE(640), .V_ACTIVE(480)) dut (
    .clk_25    (clk_25),
    .rst_n     (rst_n),
    .valid     (valid),
    .mask      (mask),
    .mask_x    (mask_x),
    .mask_y    (mask_y),
    .min_count (min_count),
    .box_valid (box_valid),
    .box_found (box_found),
    .box_x0    (box_x0),
    .box_x1    (box_x1),
    .box_y0    (box_y0),
    .box_y1    (box_y1),
    .obj_count (obj_count),
    .frame_err (frame_err)
  );

  always #20 clk_25 = ~clk_25;

  always @(negedge clk_25) begin
    if (box_valid === 1'b1) bv_cnt++;
    if (frame_err === 1'b1) fe_cnt++;
  end

  task automatic strobe(input int x, input int y, input logic m);
    valid  = 1'b1;
    mask_x = 10'(x);
    mask_y = 10'(y);
    mask   = m;
    @(posedge clk_25);
    #1;
  endtask

  task automatic idle_cycle();
    valid = 1'b0;
    @(posedge clk_25);
    #1;
  endtask

  task automatic test_reset();
    int bv0;
    rst_n = 1'b0; valid = 1'b0; mask = 1'b1; mask_x = '0; mask_y = '0; min_count = '0;
    repeat (3) @(posedge clk_25);
    #1;
    rst_n = 1'b1;
    tests_run++;
    if (box_valid !== 1'b0 || box_found !== 1'b0 || frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: valid=%b found=%b err=%b, required 0 0 0", box_valid, box_found, frame_err);
    end
    tests_run++;
    if (box_x0 !== 10'd0 || box_x1 !== 10'd0 || box_y0 !== 10'd0 || box_y1 !== 10'd0 || obj_count !== 20'd0) begin
      tests_failed++;
      $display("FAIL reset_box: %0d %0d %0d %0d cnt=%0d, required all 0", box_x0, box_x1, box_y0, box_y1, obj_count);
    end
    bv0 = bv_cnt;
    strobe(639, 479, 0);
    idle_cycle();
    tests_run++;
    if (bv_cnt != bv0 || obj_count !== 20'd0) begin
      tests_failed++;
      $display("FAIL idle_ignore: pulses=%0d cnt=%0d, required 0 0", bv_cnt - bv0, obj_count);
    end
  endtask

  task automatic test_big_box();
    int bv0;
    min_count = 20'd10;
    bv0 = bv_cnt;
    strobe(0, 0, 1);
    for (int y = 50; y <= 89; y++)
      for (int x = 100; x <= 199; x++)
        strobe(x, y, 0);
    strobe(700, 60, 0);
    strobe(150, 500, 0);
    strobe(639, 479, 1);
    tests_run++;
    if (box_valid !== 1'b1 || bv_cnt != bv0) begin
      tests_failed++;
      $display("FAIL big_latency: box_valid=%b early_pulses=%0d, required 1 0", box_valid, bv_cnt - bv0);
    end
    tests_run++;
    if (box_found !== 1'b1 || box_x0 !== 10'd100 || box_x1 !== 10'd199 || box_y0 !== 10'd50 || box_y1 !== 10'd89) begin
      tests_failed++;
      $display("FAIL big_box: found=%b %0d %0d %0d %0d, required 1 100 199 50 89", box_found, box_x0, box_x1, box_y0, box_y1);
    end
    tests_run++;
    if (obj_count !== 20'd4000) begin
      tests_failed++;
      $display("FAIL big_count: %0d, required 4000", obj_count);
    end
    idle_cycle();
    tests_run++;
    if (box_valid !== 1'b0 || box_x0 !== 10'd100 || box_found !== 1'b1 || bv_cnt != bv0 + 1) begin
      tests_failed++;
      $display("FAIL big_hold: valid=%b x0=%0d found=%b pulses=%0d, required 0 100 1 1", box_valid, box_x0, box_found, bv_cnt - bv0);
    end
  endtask

  task automatic test_empty();
    min_count = 20'd0;
    strobe(0, 0, 1);
    strobe(5, 5, 1);
    strobe(639, 479, 1);
    tests_run++;
    if (box_valid !== 1'b1 || box_found !== 1'b0 || obj_count !== 20'd0) begin
      tests_failed++;
      $display("FAIL empty_flags: valid=%b found=%b cnt=%0d, required 1 0 0", box_valid, box_found, obj_count);
    end
    tests_run++;
    if (box_x0 !== 10'd0 || box_x1 !== 10'd0 || box_y0 !== 10'd0 || box_y1 !== 10'd0) begin
      tests_failed++;
      $display("FAIL empty_box: %0d %0d %0d %0d, required all 0", box_x0, box_x1, box_y0, box_y1);
    end
    idle_cycle();
  endtask

  task automatic test_min_count();
    for (int pass = 0; pass < 2; pass++) begin
      min_count = (pass == 0) ? 20'd6 : 20'd5;
      strobe(0, 0, 1);
      strobe(10, 20, 0);
      strobe(30, 5, 0);
      strobe(15, 40, 0);
      strobe(600, 470, 0);
      strobe(3, 3, 0);
      strobe(639, 479, 1);
      tests_run++;
      if (box_valid !== 1'b1 || obj_count !== 20'd5) begin
        tests_failed++;
        $display("FAIL min_count_cnt pass%0d: valid=%b cnt=%0d, required 1 5", pass, box_valid, obj_count);
      end
      if (pass == 0) begin
        tests_run++;
        if (box_found !== 1'b0 || box_x1 !== 10'd0 || box_y1 !== 10'd0) begin
          tests_failed++;
          $display("FAIL min_count_below: found=%b x1=%0d y1=%0d, required 0 0 0", box_found, box_x1, box_y1);
        end
      end else begin
        tests_run++;
        if (box_found !== 1'b1 || box_x0 !== 10'd3 || box_x1 !== 10'd600 || box_y0 !== 10'd3 || box_y1 !== 10'd470) begin
          tests_failed++;
          $display("FAIL min_count_equal: found=%b %0d %0d %0d %0d, required 1 3 600 3 470", box_found, box_x0, box_x1, box_y0, box_y1);
        end
      end
      idle_cycle();
    end
  endtask

  task automatic test_abort();
    int bv0, fe0;
    min_count = 20'd1;
    bv0 = bv_cnt;
    fe0 = fe_cnt;
    strobe(0, 0, 0);
    strobe(5, 5, 0);
    strobe(320, 240, 1);
    strobe(0, 0, 1);
    tests_run++;
    if (frame_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_pulse: frame_err=%b, required 1", frame_err);
    end
    strobe(700, 10, 0);
    tests_run++;
    if (frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_width: frame_err=%b, required 0", frame_err);
    end
    strobe(639, 0, 1);
    strobe(0, 479, 1);
    strobe(639, 479, 0);
    tests_run++;
    if (box_valid !== 1'b1 || box_found !== 1'b1 || obj_count !== 20'd1) begin
      tests_failed++;
      $display("FAIL abort_report: valid=%b found=%b cnt=%0d, required 1 1 1", box_valid, box_found, obj_count);
    end
    tests_run++;
    if (box_x0 !== 10'd639 || box_x1 !== 10'd639 || box_y0 !== 10'd479 || box_y1 !== 10'd479) begin
      tests_failed++;
      $display("FAIL abort_box: %0d %0d %0d %0d, required 639 639 479 479", box_x0, box_x1, box_y0, box_y1);
    end
    idle_cycle();
    tests_run++;
    if (fe_cnt != fe0 + 1 || bv_cnt != bv0 + 1) begin
      tests_failed++;
      $display("FAIL abort_pulses: err=%0d valid=%0d, required 1 1", fe_cnt - fe0, bv_cnt - bv0);
    end
  endtask

  task automatic test_back_to_back();
    min_count = 20'd1;
    strobe(0, 0, 0);
    strobe(1, 0, 0);
    strobe(639, 479, 1);
    tests_run++;
    if (box_valid !== 1'b1 || obj_count !== 20'd2 || box_x0 !== 10'd0 || box_x1 !== 10'd1 || box_y0 !== 10'd0 || box_y1 !== 10'd0) begin
      tests_failed++;
      $display("FAIL b2b_first: valid=%b cnt=%0d %0d %0d %0d %0d, required 1 2 0 1 0 0", box_valid, obj_count, box_x0, box_x1, box_y0, box_y1);
    end
    strobe(0, 0, 0);
    tests_run++;
    if (box_valid !== 1'b0 || frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_restart: valid=%b err=%b, required 0 0", box_valid, frame_err);
    end
    strobe(2, 1, 0);
    strobe(639, 479, 1);
    tests_run++;
    if (box_valid !== 1'b1 || obj_count !== 20'd2 || box_x0 !== 10'd0 || box_x1 !== 10'd2 || box_y0 !== 10'd0 || box_y1 !== 10'd1) begin
      tests_failed++;
      $display("FAIL b2b_second: valid=%b cnt=%0d %0d %0d %0d %0d, required 1 2 0 2 0 1", box_valid, obj_count, box_x0, box_x1, box_y0, box_y1);
    end
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    int bv0, fe0;
    min_count = 20'd1;
    strobe(0, 0, 0);
    strobe(400, 300, 0);
    valid = 1'b0;
    #5;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (box_found !== 1'b0 || obj_count !== 20'd0 || box_x1 !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_async: found=%b cnt=%0d x1=%0d, required 0 0 0", box_found, obj_count, box_x1);
    end
    @(posedge clk_25);
    #1;
    rst_n = 1'b1;
    bv0 = bv_cnt;
    fe0 = fe_cnt;
    strobe(401, 300, 0);
    strobe(639, 479, 0);
    idle_cycle();
    tests_run++;
    if (bv_cnt != bv0 || fe_cnt != fe0 || obj_count !== 20'd0 || box_y1 !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_discard: valid=%0d err=%0d cnt=%0d y1=%0d, required 0 0 0 0", bv_cnt - bv0, fe_cnt - fe0, obj_count, box_y1);
    end
    strobe(0, 0, 1);
    strobe(639, 479, 0);
    tests_run++;
    if (box_valid !== 1'b1 || obj_count !== 20'd1 || box_x0 !== 10'd639) begin
      tests_failed++;
      $display("FAIL reset_recover: valid=%b cnt=%0d x0=%0d, required 1 1 639", box_valid, obj_count, box_x0);
    end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_big_box();
    test_empty();
    test_min_count();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mask_bbox.md
MASK_BBOX -- requirements
Module: mask_bbox

Interface
REQ-001 Parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 clk_25  input  1  pixel clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 valid  input  1  one-cycle strobe; mask/mask_x/mask_y are meaningful only when high.
REQ-006 mask  input  1  0 = object pixel, 1 = background pixel.
REQ-007 mask_x  input  10  pixel column of the current strobe.
REQ-008 mask_y  input  10  pixel row of the current strobe.
REQ-009 min_count  input  20  minimum object-pixel count for a box to be reported as found; sampled at frame end.
REQ-010 box_valid  output  1  one-cycle pulse; box outputs updated for the frame just finished.
REQ-011 box_found  output  1  1 = object count >= min_count in the reported frame.
REQ-012 box_x0, box_x1  output  10 each  min/max object column of the reported frame.
REQ-013 box_y0, box_y1  output  10 each  min/max object row of the reported frame.
REQ-014 obj_count  output  20  object-pixel count of the reported frame, saturating.
REQ-015 frame_err  output  1  one-cycle pulse; a frame was aborted before completion.

Function
REQ-016 FSM states: IDLE, ACCUM, REPORT.
REQ-017 IDLE: ignore all strobes except valid with (mask_x,mask_y)=(0,0); that strobe enters ACCUM and is the first accumulated pixel.
REQ-018 Frame start: working min_x/min_y load 1023, max_x/max_y load 0, count loads 0, then the (0,0) pixel is applied in the same cycle.
REQ-019 ACCUM: each valid with mask=0 and mask_x<H_ACTIVE and mask_y<V_ACTIVE updates min_x, max_x, min_y, max_y, count+1.
REQ-020 count saturates at 20'hFFFFF; no wrap.
REQ-021 Strobes with mask_x>=H_ACTIVE or mask_y>=V_ACTIVE are ignored in every state.
REQ-022 Frame end: valid at (H_ACTIVE-1,V_ACTIVE-1) in ACCUM is accumulated, then the FSM enters REPORT on the same edge that registers the outputs.
REQ-023 Latency: box_valid is high exactly in the cycle after the edge sampling the last pixel; high for exactly one cycle (the REPORT cycle).
REQ-024 Found rule: final count >= min_count and count != 0 -> box_found=1 and box outputs = final min/max; otherwise box_found=0 and box_x0/x1/y0/y1=0; obj_count always = final count.
REQ-025 Box outputs and box_found hold their values until the next box_valid pulse.
REQ-026 REPORT lasts one cycle then goes to IDLE; a valid (0,0) strobe during REPORT starts a new frame directly (ACCUM), so back-to-back frames lose no pixel.
REQ-027 Abort: valid (0,0) in ACCUM -> frame_err pulses one cycle later; accumulators restart per REQ-018 with that pixel; FSM stays ACCUM; no box_valid for the aborted frame.
REQ-028 Consecutive-cycle strobes are legal; each strobe is processed independently with no back-pressure.
REQ-029 Pixels not at the frame-end coordinate never trigger REPORT, regardless of ordering.

Reset
REQ-030 rst_n low: FSM=IDLE, accumulators cleared, box_valid=0, box_found=0, box_x0/x1/y0/y1=0, obj_count=0, frame_err=0.
REQ-031 Reset asserted mid-frame discards the partial frame; no box_valid or frame_err results from it.
REQ-032 After reset release, strobes are ignored until the next (0,0) strobe.

Verification
REQ-033 Full 640x480 frame, mask=0 only in x 100..199, y 50..89, min_count=10 -> one box_valid pulse one cycle after (639,479); box_found=1, x0=100, x1=199, y0=50, y1=89, obj_count=4000.
REQ-034 Full frame all mask=1, min_count=0 -> box_valid, box_found=0, all coordinates 0, obj_count=0.
REQ-035 Frame with 5 object pixels, min_count=6 -> box_found=0, obj_count=5; same frame with min_count=5 -> box_found=1.
REQ-036 Frame aborted by a (0,0) strobe at (320,240), followed by a full frame with a single object pixel at (639,479) -> one frame_err pulse, one box_valid, x0=x1=639, y0=y1=479, obj_count=1.
REQ-037 Strobes every cycle, (0,0) in the REPORT cycle of the previous frame -> second frame accumulates its (0,0) pixel; both frames report correctly.
REQ-038 rst_n pulsed low at (400,300) mid-frame, then strobes resume at (401,300) -> no output until the next (0,0); all outputs read reset values in between.
